// File: rtl/approx_add_pkg.sv
// Shared definitions for the approximate-adder arbiter: default sizes,
// request/response bundle layouts and the round-robin grant helper.
package approx_add_pkg;

  // Default operand width, number of bypassed LSBs and counter width.
  localparam int DEF_W     = 8;
  localparam int DEF_K     = 4;
  localparam int DEF_CNT_W = 16;

  // One requester's operation at the default width.
  typedef struct packed {
    logic [DEF_W-1:0] x;
    logic [DEF_W-1:0] y;
    logic             cin;
    logic             approx;
  } req_bundle_t;

  // One registered result at the default width (carry-out is the MSB of sum).
  typedef struct packed {
    logic [DEF_W:0] sum;
    logic           id;
    logic           approx;
  } rsp_bundle_t;

  // Two-way round-robin pick.
  // bit 0 = grant requester 0, bit 1 = grant requester 1.
  // A lone valid requester always wins; on contention, ptr names the winner.
  function automatic logic [1:0] rr_grant(input logic v0,
                                          input logic v1,
                                          input logic ptr);
    logic [1:0] g;
    g = 2'b00;
    if (v0 && v1) begin
      g = ptr ? 2'b10 : 2'b01;
    end else if (v0) begin
      g = 2'b01;
    end else if (v1) begin
      g = 2'b10;
    end
    return g;
  endfunction

endpackage

// File: rtl/approx_add_core.sv
// Configurable lower-part-bypass adder. This is the only arithmetic in the
// block; the arbiter around it handles muxing, registering and counting.
//
// Exact mode:       sum = x + y + cin (zero-extended to W+1 bits).
// Approximate mode: the K low sum bits are copied from y, x[K-1] is used as
//                   a speculative carry into bit K, and cin is ignored.
// K must be in 1..W-1 so that both the bypassed and the added parts exist.
module approx_add_core #(
  parameter int W = 8,
  parameter int K = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  input  logic         approx,
  output logic [W:0]   sum
);

  logic [W:0]     exact_sum;
  logic [W-K:0]   upper_sum;
  logic [K-1:0]   lower_sum;

  // Both candidate results are formed every cycle; mode selects one.
  always_comb begin
    exact_sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
    lower_sum = y[K-1:0];
    upper_sum = {1'b0, x[W-1:K]} + {1'b0, y[W-1:K]} + {{(W-K){1'b0}}, x[K-1]};
    sum       = approx ? {upper_sum, lower_sum} : exact_sum;
  end

endmodule

// File: rtl/approx_add_arbiter.sv
// Two-requester front end for one shared approximate adder.
//
// Handshake: a transfer happens on a channel in every cycle where its valid
// and ready are both high. Requesters must hold valid and payload stable
// until they see ready. The response channel holds sum/id/approx stable
// while rsp_valid is high and rsp_ready is low.
//
// The output buffer is a single entry. A new request may be accepted in the
// same cycle the held result is popped, so with rsp_ready tied high the
// block sustains one operation per cycle. Contention is resolved
// round-robin: after requester i is served, the other one has priority.
module approx_add_arbiter
  import approx_add_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int K     = DEF_K,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [W-1:0]     req0_x,
  input  logic [W-1:0]     req0_y,
  input  logic             req0_cin,
  input  logic             req0_approx,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_x,
  input  logic [W-1:0]     req1_y,
  input  logic             req1_cin,
  input  logic             req1_approx,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W:0]       rsp_sum,
  output logic             rsp_id,
  output logic             rsp_approx,
  output logic [CNT_W-1:0] approx_count
);

  // Width-parameterised views of the package bundles.
  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         cin;
    logic         approx;
  } req_t;

  typedef struct packed {
    logic [W:0] sum;
    logic       id;
    logic       approx;
  } rsp_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  req_t       req0;
  req_t       req1;
  req_t       sel;
  rsp_t       rsp_q;
  logic       rsp_valid_q;
  logic       ptr_q;
  logic       can_accept;
  logic [1:0] grant;
  logic       accept;
  logic [W:0] core_sum;
  logic [CNT_W-1:0] count_q;

  assign req0 = {req0_x, req0_y, req0_cin, req0_approx};
  assign req1 = {req1_x, req1_y, req1_cin, req1_approx};

  // Arbitration: grant only when the buffer is empty or being drained this
  // cycle. Ready is forced low while reset is asserted so nothing can be
  // accepted in a cycle whose state is about to be discarded.
  always_comb begin
    can_accept = !rsp_valid_q || rsp_ready;
    grant      = rr_grant(req0_valid, req1_valid, ptr_q);
    req0_ready = reset_n && can_accept && grant[0];
    req1_ready = reset_n && can_accept && grant[1];
    accept     = req0_ready || req1_ready;
    sel        = grant[1] ? req1 : req0;
  end

  approx_add_core #(
    .W (W),
    .K (K)
  ) u_core (
    .x      (sel.x),
    .y      (sel.y),
    .cin    (sel.cin),
    .approx (sel.approx),
    .sum    (core_sum)
  );

  // Output buffer, round-robin pointer and saturating approximate counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      ptr_q       <= 1'b0;
      count_q     <= '0;
    end else if (accept) begin
      rsp_valid_q   <= 1'b1;
      rsp_q.sum     <= core_sum;
      rsp_q.id      <= grant[1];
      rsp_q.approx  <= sel.approx;
      ptr_q         <= ~grant[1];
      if (sel.approx && (count_q != CNT_MAX)) begin
        count_q <= count_q + 1'b1;
      end
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_sum      = rsp_q.sum;
  assign rsp_id       = rsp_q.id;
  assign rsp_approx   = rsp_q.approx;
  assign approx_count = count_q;

endmodule
